// File: rtl/msx_key_scanner_if.sv
// Keyboard matrix and PPI-facing signals of the MSX key scanner.
// master = scanner, slave = keyboard model / PPI side.
interface msx_key_scanner_if;
    logic [10:0] key_y_n;
    logic [7:0]  key_x_n;
    logic [3:0]  matrix_y;
    logic [7:0]  matrix_x;
    logic        scan_done;

    modport master (
        output key_y_n,
        input  key_x_n,
        input  matrix_y,
        output matrix_x,
        output scan_done
    );

    modport slave (
        input  key_y_n,
        output key_x_n,
        output matrix_y,
        input  matrix_x,
        input  scan_done
    );
endinterface

// File: rtl/msx_key_scanner.sv
// Debounced MSX keyboard matrix scanner: walks 11 rows, debounces the
// sampled columns per row, and serves the stable image to the PPI.
module msx_key_scanner #(
    parameter int SETTLE_CYCLES  = 86,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              reset,
    msx_key_scanner_if.master bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {SELECT, SETTLE, SAMPLE} state_e;

    state_e        state_q;
    logic [3:0]    row_q;
    logic [SW-1:0] settle_q;
    logic [10:0]   key_y_q;
    logic          scan_done_q;
    logic [7:0]    matrix_x_q;
    logic [7:0]    xs1_q;
    logic [7:0]    xs_q;
    logic [7:0]    cand_q   [11];
    logic [2:0]    cnt_q    [11];
    logic [7:0]    stable_q [11];

    logic [3:0]    cnt_inc;
    logic [3:0]    cnt_d;
    logic          commit_d;

    // New debounce count for the row being sampled; a changed sample restarts at 1.
    always_comb begin
        cnt_inc = {1'b0, cnt_q[row_q]} + 4'd1;
        if (xs_q != cand_q[row_q]) begin
            cnt_d = 4'd1;
        end else if (cnt_inc > DS) begin
            cnt_d = DS;
        end else begin
            cnt_d = cnt_inc;
        end
        commit_d = (cnt_d >= DS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SELECT;
            row_q       <= 4'd0;
            settle_q    <= '0;
            key_y_q     <= 11'h7FF;
            scan_done_q <= 1'b0;
            matrix_x_q  <= 8'hFF;
            xs1_q       <= 8'hFF;
            xs_q        <= 8'hFF;
            for (int r = 0; r < 11; r++) begin
                cand_q[r]   <= 8'hFF;
                cnt_q[r]    <= 3'd0;
                stable_q[r] <= 8'hFF;
            end
        end else begin
            xs1_q       <= bus.key_x_n;
            xs_q        <= xs1_q;
            scan_done_q <= 1'b0;
            matrix_x_q  <= (bus.matrix_y <= 4'd10) ?
                           stable_q[bus.matrix_y] : 8'hFF;

            unique case (state_q)
                SELECT: begin
                    key_y_q  <= ~(11'd1 << row_q);
                    settle_q <= '0;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q     <= SAMPLE;
                        scan_done_q <= (row_q == 4'd10);
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                SAMPLE: begin
                    cand_q[row_q] <= xs_q;
                    cnt_q[row_q]  <= cnt_d[2:0];
                    if (commit_d) begin
                        stable_q[row_q] <= xs_q;
                    end
                    row_q   <= (row_q == 4'd10) ? 4'd0 : row_q + 4'd1;
                    state_q <= SELECT;
                end
                default: state_q <= SELECT;
            endcase
        end
    end

    assign bus.key_y_n   = key_y_q;
    assign bus.scan_done = scan_done_q;
    assign bus.matrix_x  = matrix_x_q;
endmodule

// File: tb/tb_msx_key_scanner.sv
// Directed bench for msx_key_scanner with a behavioural keyboard matrix.
// Each task drives one scenario and checks its own expected values.
module tb_msx_key_scanner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] press [11];
    logic [7:0] kx;

    msx_key_scanner_if bus();

    msx_key_scanner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Matrix model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        kx = 8'hFF;
        for (int r = 0; r < 11; r++) begin
            if (!bus.key_y_n[r]) kx = kx & ~press[r];
        end
    end
    assign bus.key_x_n = kx;

    task automatic wait_scans(input int n, output int at);
        int k;
        at = 0;
        for (int i = 0; i < n; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus.scan_done && k < 2000);
            if (!bus.scan_done) begin
                total++;
                bad++;
                $display("FAIL scan_done_timeout: waited=%0d required=<2000", k);
                return;
            end
            at = cyc;
        end
    endtask

    task automatic read_row(input logic [3:0] y, output logic [7:0] v);
        @(negedge clk);
        bus.matrix_y = y;
        @(negedge clk);
        v = bus.matrix_x;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.key_y_n !== 11'h7FF) begin
            bad++;
            $display("FAIL reset_key_y: got=%h want=7ff", bus.key_y_n);
        end
        total++;
        if (bus.matrix_x !== 8'hFF) begin
            bad++;
            $display("FAIL reset_matrix_x: got=%h want=ff", bus.matrix_x);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.key_y_n !== 11'h7FE) begin
            bad++;
            $display("FAIL first_select: got=%h want=7fe", bus.key_y_n);
        end
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.key_y_n !== 11'h7FF) begin
            bad++;
            $display("FAIL async_key_y: got=%h want=7ff", bus.key_y_n);
        end
        total++;
        if (bus.matrix_x !== 8'hFF || bus.scan_done !== 1'b0) begin
            bad++;
            $display("FAIL async_outs: got=%h/%b want=ff/0",
                     bus.matrix_x, bus.scan_done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.key_y_n !== 11'h7FE) begin
            bad++;
            $display("FAIL rerelease_select: got=%h want=7fe", bus.key_y_n);
        end
    endtask

    task automatic test_idle();
        int t0, t1, k;
        logic [10:0] prev, exp;
        logic [7:0] v;
        wait_scans(1, t0);
        wait_scans(1, t1);
        total++;
        if (t1 - t0 !== 968) begin
            bad++;
            $display("FAIL scan_period: got=%0d want=968", t1 - t0);
        end
        prev = bus.key_y_n;
        total++;
        if (prev !== 11'h3FF) begin
            bad++;
            $display("FAIL row10_drive: got=%h want=3ff", prev);
        end
        for (int i = 0; i < 12; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (bus.key_y_n === prev && k < 200);
            exp = 11'h7FF ^ (11'd1 << (i % 11));
            total++;
            if (bus.key_y_n !== exp) begin
                bad++;
                $display("FAIL row_walk_%0d: got=%h want=%h", i, bus.key_y_n, exp);
            end
            prev = bus.key_y_n;
        end
        for (int y = 0; y < 11; y++) begin
            read_row(4'(y), v);
            total++;
            if (v !== 8'hFF) begin
                bad++;
                $display("FAIL idle_row_%0d: got=%h want=ff", y, v);
            end
        end
    endtask

    task automatic test_press();
        int t;
        logic [7:0] v;
        wait_scans(1, t);
        press[3] = 8'h20;
        bus.matrix_y = 4'd3;
        wait_scans(3, t);
        total++;
        if (bus.matrix_x !== 8'hFF) begin
            bad++;
            $display("FAIL press_3scans: got=%h want=ff", bus.matrix_x);
        end
        wait_scans(1, t);
        total++;
        if (bus.matrix_x !== 8'hDF) begin
            bad++;
            $display("FAIL press_commit: got=%h want=df", bus.matrix_x);
        end
        for (int y = 0; y < 11; y++) begin
            if (y != 3) begin
                read_row(4'(y), v);
                total++;
                if (v !== 8'hFF) begin
                    bad++;
                    $display("FAIL press_other_%0d: got=%h want=ff", y, v);
                end
            end
        end
    endtask

    task automatic test_read_path();
        logic [7:0] v;
        for (int y = 11; y < 16; y++) begin
            read_row(4'(y), v);
            total++;
            if (v !== 8'hFF) begin
                bad++;
                $display("FAIL oob_row_%0d: got=%h want=ff", y, v);
            end
        end
        read_row(4'd0, v);
        @(posedge clk);
        #1;
        bus.matrix_y = 4'd3;
        @(negedge clk);
        total++;
        if (bus.matrix_x !== 8'hFF) begin
            bad++;
            $display("FAIL sel3_early: got=%h want=ff", bus.matrix_x);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.matrix_x !== 8'hDF) begin
            bad++;
            $display("FAIL sel3_latency: got=%h want=df", bus.matrix_x);
        end
        bus.matrix_y = 4'd0;
        @(negedge clk);
        total++;
        if (bus.matrix_x !== 8'hDF) begin
            bad++;
            $display("FAIL sel0_early: got=%h want=df", bus.matrix_x);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.matrix_x !== 8'hFF) begin
            bad++;
            $display("FAIL sel0_latency: got=%h want=ff", bus.matrix_x);
        end
    endtask

    task automatic test_release();
        int t;
        wait_scans(1, t);
        press[3] = 8'h00;
        bus.matrix_y = 4'd3;
        wait_scans(3, t);
        total++;
        if (bus.matrix_x !== 8'hDF) begin
            bad++;
            $display("FAIL release_3scans: got=%h want=df", bus.matrix_x);
        end
        wait_scans(1, t);
        total++;
        if (bus.matrix_x !== 8'hFF) begin
            bad++;
            $display("FAIL release_commit: got=%h want=ff", bus.matrix_x);
        end
    endtask

    task automatic test_bounce();
        int t;
        bus.matrix_y = 4'd7;
        wait_scans(1, t);
        for (int i = 0; i < 12; i++) begin
            press[7] = (i % 2 == 0) ? 8'h01 : 8'h00;
            wait_scans(1, t);
            total++;
            if (bus.matrix_x !== 8'hFF) begin
                bad++;
                $display("FAIL bounce_scan_%0d: got=%h want=ff", i, bus.matrix_x);
            end
        end
        press[7] = 8'h00;
    endtask

    task automatic test_reset_held();
        int t;
        press[3] = 8'h20;
        bus.matrix_y = 4'd3;
        wait_scans(5, t);
        total++;
        if (bus.matrix_x !== 8'hDF) begin
            bad++;
            $display("FAIL held_commit: got=%h want=df", bus.matrix_x);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.matrix_x !== 8'hFF) begin
            bad++;
            $display("FAIL held_reset: got=%h want=ff", bus.matrix_x);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_scans(3, t);
        total++;
        if (bus.matrix_x !== 8'hFF) begin
            bad++;
            $display("FAIL held_3scans: got=%h want=ff", bus.matrix_x);
        end
        wait_scans(1, t);
        total++;
        if (bus.matrix_x !== 8'hDF) begin
            bad++;
            $display("FAIL held_recommit: got=%h want=df", bus.matrix_x);
        end
        press[3] = 8'h00;
    endtask

    initial begin
        for (int r = 0; r < 11; r++) press[r] = 8'h00;
        bus.matrix_y = 4'd0;
        test_reset();
        test_idle();
        test_press();
        test_read_path();
        test_release();
        test_bounce();
        test_reset_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
